// File: rtl/decode_if.sv
// -----------------------------------------------------------------------------
// decode_if
//
// Purpose:
//   Bundles the decode-stage signals: the IF/ID instruction and its control
//   bits, the hazard inputs from the execute stage, the write-back port, and
//   the ID/EX register outputs consumed by the execute stage.
//
// Modports:
//   master - upstream/downstream pipeline view: drives the decode inputs and
//            the write-back port, observes stallOut and the ID/EX outputs.
//   slave  - the decode stage itself.
//
// Signals (all synchronous to the decode-stage clock):
//   ifValid, instruction32, regDst, regWrite, memRead, flush  (to decode)
//   exMemRead, exRt                                           (to decode)
//   wbRegWrite, wbWriteReg, wbWriteData                       (to decode)
//   stallOut, idexValid, idexReadData1/2, idexExtImm, idexRs, idexRt,
//   idexDestReg, idexRegWrite, idexMemRead, idexOpcode, idexFunct,
//   idexShamt                                                 (from decode)
// -----------------------------------------------------------------------------
interface decode_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
);
  // Instruction and control from IF/ID
  logic                      ifValid;
  logic [31:0]               instruction32;
  logic                      regDst;
  logic                      regWrite;
  logic                      memRead;
  logic                      flush;

  // Load-use hazard inputs from the instruction currently in ID/EX
  logic                      exMemRead;
  logic [REG_ADDR_WIDTH-1:0] exRt;

  // Write-back port
  logic                      wbRegWrite;
  logic [REG_ADDR_WIDTH-1:0] wbWriteReg;
  logic [DATA_WIDTH-1:0]     wbWriteData;

  // Decode results
  logic                      stallOut;
  logic                      idexValid;
  logic [DATA_WIDTH-1:0]     idexReadData1;
  logic [DATA_WIDTH-1:0]     idexReadData2;
  logic [DATA_WIDTH-1:0]     idexExtImm;
  logic [REG_ADDR_WIDTH-1:0] idexRs;
  logic [REG_ADDR_WIDTH-1:0] idexRt;
  logic [REG_ADDR_WIDTH-1:0] idexDestReg;
  logic                      idexRegWrite;
  logic                      idexMemRead;
  logic [5:0]                idexOpcode;
  logic [5:0]                idexFunct;
  logic [4:0]                idexShamt;

  modport master (
    output ifValid, instruction32, regDst, regWrite, memRead, flush,
    output exMemRead, exRt,
    output wbRegWrite, wbWriteReg, wbWriteData,
    input  stallOut, idexValid, idexReadData1, idexReadData2, idexExtImm,
    input  idexRs, idexRt, idexDestReg, idexRegWrite, idexMemRead,
    input  idexOpcode, idexFunct, idexShamt
  );

  modport slave (
    input  ifValid, instruction32, regDst, regWrite, memRead, flush,
    input  exMemRead, exRt,
    input  wbRegWrite, wbWriteReg, wbWriteData,
    output stallOut, idexValid, idexReadData1, idexReadData2, idexExtImm,
    output idexRs, idexRt, idexDestReg, idexRegWrite, idexMemRead,
    output idexOpcode, idexFunct, idexShamt
  );
endinterface

// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
//
// Purpose:
//   MIPS instruction-decode stage. Splits the instruction into its fields,
//   reads a two-port register file (with write-through bypass from the
//   write-back port), extends the immediate according to the opcode, detects
//   load-use hazards, and captures everything in the ID/EX register. Flush or
//   stall turn the ID/EX load into a bubble.
//
// Ports:
//   clk     - rising-edge clock
//   resetN  - asynchronous active-low reset; clears register file and ID/EX
//   dif     - decode_if.slave bundle (instruction, control, hazard inputs,
//             write-back port, stallOut and all ID/EX outputs)
//
// Parameters:
//   DATA_WIDTH     - datapath/register width (at least 32)
//   REG_ADDR_WIDTH - register index width; the file has 2**REG_ADDR_WIDTH
//                    entries and rs/rt/rd take the low bits of their fields
// -----------------------------------------------------------------------------
module decode_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic    clk,
  input  logic    resetN,
  decode_if.slave dif
);

  localparam int DEPTH = 2 ** REG_ADDR_WIDTH;

  // Opcodes whose immediate is zero-extended, plus lui
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_XORI = 6'h0E;
  localparam logic [5:0] OP_LUI  = 6'h0F;

  // ---------------------------------------------------------------------------
  // Immediate extension selected by opcode
  // ---------------------------------------------------------------------------
  function automatic logic [DATA_WIDTH-1:0] ext_imm(input logic [5:0]  op,
                                                     input logic [15:0] imm);
    logic [DATA_WIDTH-1:0] r;
    case (op)
      OP_ANDI, OP_ORI, OP_XORI: begin
        r        = '0;
        r[15:0]  = imm;
      end
      OP_LUI: begin
        // Upper half of the low 32 bits; anything above bit 31 stays zero
        r        = '0;
        r[31:16] = imm;
      end
      default: r = {{(DATA_WIDTH-16){imm[15]}}, imm};
    endcase
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Field split
  // ---------------------------------------------------------------------------
  logic [5:0]                opcode;
  logic [4:0]                rs_field;
  logic [4:0]                rt_field;
  logic [4:0]                rd_field;
  logic [4:0]                shamt;
  logic [5:0]                funct;
  logic [15:0]               imm;
  logic [REG_ADDR_WIDTH-1:0] rs;
  logic [REG_ADDR_WIDTH-1:0] rt;
  logic [REG_ADDR_WIDTH-1:0] rd;

  assign opcode   = dif.instruction32[31:26];
  assign rs_field = dif.instruction32[25:21];
  assign rt_field = dif.instruction32[20:16];
  assign rd_field = dif.instruction32[15:11];
  assign shamt    = dif.instruction32[10:6];
  assign funct    = dif.instruction32[5:0];
  assign imm      = dif.instruction32[15:0];

  assign rs = rs_field[REG_ADDR_WIDTH-1:0];
  assign rt = rt_field[REG_ADDR_WIDTH-1:0];
  assign rd = rd_field[REG_ADDR_WIDTH-1:0];

  // ---------------------------------------------------------------------------
  // Register file: register 0 is never written, so it always reads 0
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic                  wb_en;

  assign wb_en = dif.wbRegWrite && (dif.wbWriteReg != '0);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wb_en) begin
      regs_q[dif.wbWriteReg] <= dif.wbWriteData;
    end
  end

  // Read ports with write-through bypass: a same-cycle write-back is seen
  // before it lands in the file.
  logic [DATA_WIDTH-1:0] read_data1;
  logic [DATA_WIDTH-1:0] read_data2;

  always_comb begin
    read_data1 = '0;
    if (rs != '0) begin
      if (wb_en && (dif.wbWriteReg == rs)) begin
        read_data1 = dif.wbWriteData;
      end else begin
        read_data1 = regs_q[rs];
      end
    end
  end

  always_comb begin
    read_data2 = '0;
    if (rt != '0) begin
      if (wb_en && (dif.wbWriteReg == rt)) begin
        read_data2 = dif.wbWriteData;
      end else begin
        read_data2 = regs_q[rt];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Destination, gated control and load-use hazard
  // ---------------------------------------------------------------------------
  logic [REG_ADDR_WIDTH-1:0] dest_reg;
  logic                      reg_write_eff;
  logic                      mem_read_eff;
  logic                      stall;

  assign dest_reg      = dif.regDst ? rd : rt;
  assign reg_write_eff = dif.regWrite && dif.ifValid && (dest_reg != '0);
  assign mem_read_eff  = dif.memRead && dif.ifValid;

  // The bypass does not cancel a stall: the load result is not yet available
  // regardless of what write-back is doing this cycle.
  assign stall = dif.ifValid && dif.exMemRead && (dif.exRt != '0) &&
                 ((dif.exRt == rs) || (dif.exRt == rt));

  assign dif.stallOut = stall;

  // ---------------------------------------------------------------------------
  // ID/EX next-state: bubble by default, full load when neither flushed nor
  // stalled. Data fields load even for an invalid instruction.
  // ---------------------------------------------------------------------------
  logic                      valid_d,    valid_q;
  logic [DATA_WIDTH-1:0]     rd1_d,      rd1_q;
  logic [DATA_WIDTH-1:0]     rd2_d,      rd2_q;
  logic [DATA_WIDTH-1:0]     ext_d,      ext_q;
  logic [REG_ADDR_WIDTH-1:0] rs_d,       rs_q;
  logic [REG_ADDR_WIDTH-1:0] rt_d,       rt_q;
  logic [REG_ADDR_WIDTH-1:0] dest_d,     dest_q;
  logic                      regwrite_d, regwrite_q;
  logic                      memread_d,  memread_q;
  logic [5:0]                opcode_d,   opcode_q;
  logic [5:0]                funct_d,    funct_q;
  logic [4:0]                shamt_d,    shamt_q;

  always_comb begin
    valid_d    = 1'b0;
    rd1_d      = '0;
    rd2_d      = '0;
    ext_d      = '0;
    rs_d       = '0;
    rt_d       = '0;
    dest_d     = '0;
    regwrite_d = 1'b0;
    memread_d  = 1'b0;
    opcode_d   = '0;
    funct_d    = '0;
    shamt_d    = '0;
    if (!dif.flush && !stall) begin
      valid_d    = dif.ifValid;
      rd1_d      = read_data1;
      rd2_d      = read_data2;
      ext_d      = ext_imm(opcode, imm);
      rs_d       = rs;
      rt_d       = rt;
      dest_d     = dest_reg;
      regwrite_d = reg_write_eff;
      memread_d  = mem_read_eff;
      opcode_d   = opcode;
      funct_d    = funct;
      shamt_d    = shamt;
    end
  end

  // ---------------------------------------------------------------------------
  // ID/EX register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      valid_q    <= 1'b0;
      rd1_q      <= '0;
      rd2_q      <= '0;
      ext_q      <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      dest_q     <= '0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      opcode_q   <= '0;
      funct_q    <= '0;
      shamt_q    <= '0;
    end else begin
      valid_q    <= valid_d;
      rd1_q      <= rd1_d;
      rd2_q      <= rd2_d;
      ext_q      <= ext_d;
      rs_q       <= rs_d;
      rt_q       <= rt_d;
      dest_q     <= dest_d;
      regwrite_q <= regwrite_d;
      memread_q  <= memread_d;
      opcode_q   <= opcode_d;
      funct_q    <= funct_d;
      shamt_q    <= shamt_d;
    end
  end

  assign dif.idexValid     = valid_q;
  assign dif.idexReadData1 = rd1_q;
  assign dif.idexReadData2 = rd2_q;
  assign dif.idexExtImm    = ext_q;
  assign dif.idexRs        = rs_q;
  assign dif.idexRt        = rt_q;
  assign dif.idexDestReg   = dest_q;
  assign dif.idexRegWrite  = regwrite_q;
  assign dif.idexMemRead   = memread_q;
  assign dif.idexOpcode    = opcode_q;
  assign dif.idexFunct     = funct_q;
  assign dif.idexShamt     = shamt_q;

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

  logic clk = 1'b0;
  logic resetN;

  always #5 clk = ~clk;

  decode_if #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) d32 ();
  decode_if #(.DATA_WIDTH(64), .REG_ADDR_WIDTH(5)) d64 ();

  decode_stage #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut32 (
    .clk(clk), .resetN(resetN), .dif(d32.slave));
  decode_stage #(.DATA_WIDTH(64), .REG_ADDR_WIDTH(5)) dut64 (
    .clk(clk), .resetN(resetN), .dif(d64.slave));

  // The 64-bit instance follows the 32-bit stimulus
  assign d64.ifValid       = d32.ifValid;
  assign d64.instruction32 = d32.instruction32;
  assign d64.regDst        = d32.regDst;
  assign d64.regWrite      = d32.regWrite;
  assign d64.memRead       = d32.memRead;
  assign d64.flush         = d32.flush;
  assign d64.exMemRead     = d32.exMemRead;
  assign d64.exRt          = d32.exRt;
  assign d64.wbRegWrite    = d32.wbRegWrite;
  assign d64.wbWriteReg    = d32.wbWriteReg;
  assign d64.wbWriteData   = {32'h0, d32.wbWriteData};

  typedef struct packed {
    logic        v;
    logic [31:0] rd1, rd2, ext;
    logic [63:0] ext64;
    logic [4:0]  rs, rt, dst;
    logic        rw, mr;
    logic [5:0]  op, fn;
    logic [4:0]  sh;
  } idex_t;

  int nassert = 0;
  int nfail   = 0;
  logic [31:0] mdl [32];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference behaviour of one decode cycle, from the instruction-level rules
  function automatic idex_t model(output logic st);
    idex_t e;
    logic [31:0] ins;
    logic [4:0]  rs, rt, rd, dst;
    logic [15:0] imm;
    logic [5:0]  op;
    logic        wbhit;
    ins = d32.instruction32;
    op  = ins[31:26]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
    imm = ins[15:0];
    dst = d32.regDst ? rd : rt;
    st  = d32.ifValid && d32.exMemRead && d32.exRt != 0 &&
          (d32.exRt == rs || d32.exRt == rt);
    e = '0;
    if (!d32.flush && !st) begin
      wbhit = d32.wbRegWrite && d32.wbWriteReg != 0;
      e.v   = d32.ifValid;
      e.rd1 = (rs == 0) ? 32'h0 : (wbhit && d32.wbWriteReg == rs) ? d32.wbWriteData : mdl[rs];
      e.rd2 = (rt == 0) ? 32'h0 : (wbhit && d32.wbWriteReg == rt) ? d32.wbWriteData : mdl[rt];
      if (op >= 6'h0C && op <= 6'h0E) begin
        e.ext = imm; e.ext64 = imm;
      end else if (op == 6'h0F) begin
        e.ext = imm * 32'h10000; e.ext64 = imm * 64'h10000;
      end else begin
        e.ext   = $signed(imm);
        e.ext64 = $signed(imm);
      end
      e.rs = rs; e.rt = rt; e.dst = dst;
      e.rw = d32.regWrite && d32.ifValid && dst != 0;
      e.mr = d32.memRead && d32.ifValid;
      e.op = op; e.fn = ins[5:0]; e.sh = ins[10:6];
    end
    return e;
  endfunction

  task automatic chk_idex(input string tag, input idex_t e);
    chk({tag, ".valid"}, d32.idexValid,     e.v);
    chk({tag, ".rd1"},   d32.idexReadData1, e.rd1);
    chk({tag, ".rd2"},   d32.idexReadData2, e.rd2);
    chk({tag, ".ext"},   d32.idexExtImm,    e.ext);
    chk({tag, ".ext64"}, d64.idexExtImm,    e.ext64);
    chk({tag, ".rs"},    d32.idexRs,        e.rs);
    chk({tag, ".rt"},    d32.idexRt,        e.rt);
    chk({tag, ".dest"},  d32.idexDestReg,   e.dst);
    chk({tag, ".rw"},    d32.idexRegWrite,  e.rw);
    chk({tag, ".mr"},    d32.idexMemRead,   e.mr);
    chk({tag, ".op"},    d32.idexOpcode,    e.op);
    chk({tag, ".fn"},    d32.idexFunct,     e.fn);
    chk({tag, ".sh"},    d32.idexShamt,     e.sh);
  endtask

  task automatic drive(input logic iv, input logic [31:0] ins, input logic rdst,
                       input logic rw, input logic mr, input logic fl,
                       input logic exmr, input logic [4:0] exrt,
                       input logic wbw, input logic [4:0] wbr, input logic [31:0] wbd);
    d32.ifValid = iv; d32.instruction32 = ins; d32.regDst = rdst;
    d32.regWrite = rw; d32.memRead = mr; d32.flush = fl;
    d32.exMemRead = exmr; d32.exRt = exrt;
    d32.wbRegWrite = wbw; d32.wbWriteReg = wbr; d32.wbWriteData = wbd;
  endtask

  // One clock: check stall, cross the edge, update the file model, check ID/EX
  task automatic step(input string tag);
    idex_t e;
    logic  st;
    #1;
    e = model(st);
    chk({tag, ".stall"}, d32.stallOut, st);
    @(posedge clk);
    #1;
    if (d32.wbRegWrite && d32.wbWriteReg != 0) mdl[d32.wbWriteReg] = d32.wbWriteData;
    chk_idex(tag, e);
  endtask

  task automatic rand_inputs();
    logic [5:0] ops [8];
    logic [31:0] ins;
    ops = '{6'h00, 6'h23, 6'h2B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h08};
    ins = $urandom;
    ins[31:26] = ($urandom_range(0, 9) < 8) ? ops[$urandom_range(0, 7)] : ins[31:26];
    ins[25:21] = 5'($urandom_range(0, 7));
    ins[20:16] = 5'($urandom_range(0, 7));
    ins[15:11] = 5'($urandom_range(0, 7));
    drive(1'($urandom_range(0, 9) != 0), ins, 1'($urandom), 1'($urandom), 1'($urandom),
          1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 2) == 0),
          5'($urandom_range(0, 7)), 1'($urandom), 5'($urandom_range(0, 7)), $urandom);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idex_t zero;
    zero = '0;
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;

    // Reset held with arbitrary inputs
    resetN = 1'b0;
    rand_inputs();
    repeat (3) @(posedge clk);
    #1;
    chk_idex("reset_hold", zero);

    // Release with quiet inputs, between edges
    drive(0, 32'h0, 0, 0, 0, 0, 0, 5'd0, 0, 5'd0, 32'h0);
    #2 resetN = 1'b1;
    #1;
    chk("reset_rel.stall", d32.stallOut, 1'b0);
    chk_idex("reset_rel", zero);

    // Read register 5 after reset
    drive(1, 32'h00A00020, 1, 0, 0, 0, 0, 5'd0, 0, 5'd0, 32'h0);
    step("read_r5");
    chk("read_r5.val", d32.idexReadData1, 32'h0);

    // Write-back to $8 bypassed into add $10,$8,$9
    drive(1, 32'h01095020, 1, 1, 0, 0, 0, 5'd0, 1, 5'd8, 32'hDEADBEEF);
    step("wb_bypass");
    chk("wb_bypass.rd1", d32.idexReadData1, 32'hDEADBEEF);
    chk("wb_bypass.dst", d32.idexDestReg, 5'd10);
    chk("wb_bypass.rw",  d32.idexRegWrite, 1'b1);

    // Stored value read from the file, and a write to register 0
    drive(1, 32'h01005020, 1, 1, 0, 0, 0, 5'd0, 1, 5'd0, 32'h12345678);
    step("rd_stored");
    chk("rd_stored.rd1", d32.idexReadData1, 32'hDEADBEEF);
    drive(1, 32'h00000020, 1, 1, 0, 0, 0, 5'd0, 0, 5'd0, 32'h0);
    step("r0_read");
    chk("r0_read.rd1", d32.idexReadData1, 32'h0);

    // Immediate modes
    drive(1, 32'h3508FFFF, 0, 1, 0, 0, 0, 5'd0, 0, 5'd0, 32'h0);
    step("ori");
    chk("ori.imm", d32.idexExtImm, 32'h0000FFFF);
    chk("ori.imm64", d64.idexExtImm, 64'h0000_0000_0000_FFFF);
    drive(1, 32'h2108FFFF, 0, 1, 0, 0, 0, 5'd0, 0, 5'd0, 32'h0);
    step("addi");
    chk("addi.imm", d32.idexExtImm, 32'hFFFFFFFF);
    chk("addi.imm64", d64.idexExtImm, 64'hFFFF_FFFF_FFFF_FFFF);
    drive(1, 32'h3C081234, 0, 1, 0, 0, 0, 5'd0, 0, 5'd0, 32'h0);
    step("lui");
    chk("lui.imm", d32.idexExtImm, 32'h12340000);
    chk("lui.imm64", d64.idexExtImm, 64'h0000_0000_1234_0000);

    // Load-use stall, then the same with exRt=0
    drive(1, 32'h01095020, 1, 1, 0, 0, 1, 5'd8, 0, 5'd0, 32'h0);
    step("loaduse");
    chk("loaduse.valid", d32.idexValid, 1'b0);
    drive(1, 32'h01095020, 1, 1, 0, 0, 1, 5'd0, 0, 5'd0, 32'h0);
    step("loaduse_r0");
    chk("loaduse_r0.valid", d32.idexValid, 1'b1);

    // Bypass does not cancel a stall
    drive(1, 32'h01095020, 1, 1, 0, 0, 1, 5'd8, 1, 5'd8, 32'h00C0FFEE);
    #1;
    chk("stall_bypass.stall", d32.stallOut, 1'b1);
    step("stall_bypass");

    // Flush together with a stall condition
    drive(1, 32'h01095020, 1, 1, 1, 1, 1, 5'd9, 0, 5'd0, 32'h0);
    #1;
    chk("flush.stall", d32.stallOut, 1'b1);
    step("flush");
    chk_idex("flush_zero", zero);

    // Zero destination
    drive(1, 32'h01090020, 1, 1, 0, 0, 0, 5'd0, 0, 5'd0, 32'h0);
    step("zero_dst");
    chk("zero_dst.rw", d32.idexRegWrite, 1'b0);
    chk("zero_dst.v",  d32.idexValid, 1'b1);

    // Randomised traffic
    for (int i = 0; i < 250; i++) begin
      rand_inputs();
      step("rand");
    end

    // Asynchronous reset mid-cycle, then release mid-stream
    #2 resetN = 1'b0;
    #1;
    chk_idex("async_rst", zero);
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    #2 resetN = 1'b1;
    for (int i = 0; i < 40; i++) begin
      rand_inputs();
      step("post_rst");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Parametrised MIPS instruction-decode stage: it splits the fetched instruction, reads a two-port register file, extends the immediate, and captures the result in an ID/EX pipeline register. It sits between the IF/ID register and the execute stage. Compared with the earlier fixed 32-bit decode path, it adds a write-back port with write-through bypass, load-use hazard detection with stall, flush/bubble insertion, and an immediate-extension mode selected by opcode.

## Interface
- DATA_WIDTH, 32, datapath and register width; must be ≥ 32
- REG_ADDR_WIDTH, 5, register index width; file depth = 2**REG_ADDR_WIDTH, and rs/rt/rd use the low REG_ADDR_WIDTH bits of their 5-bit fields
- clk  in  1  single clock, rising edge
- resetN  in  1  asynchronous, active-low reset
- ifValid  in  1  instruction32 holds a valid instruction
- instruction32  in  32  instruction from IF/ID
- regDst  in  1  destination select: 1 = rd, 0 = rt
- regWrite  in  1  instruction writes a register
- memRead  in  1  instruction is a load
- flush  in  1  squash the instruction now in decode (taken branch/jump)
- exMemRead  in  1  instruction now in ID/EX is a load
- exRt  in  REG_ADDR_WIDTH  destination of that load
- wbRegWrite  in  1  write-back enable
- wbWriteReg  in  REG_ADDR_WIDTH  write-back register index
- wbWriteData  in  DATA_WIDTH  write-back data
- stallOut  out  1  combinational load-use stall; upstream holds PC and IF/ID while high
- idexValid  out  1  ID/EX register holds a real instruction
- idexReadData1, idexReadData2  out  DATA_WIDTH  operand values for rs and rt
- idexExtImm  out  DATA_WIDTH  extended immediate
- idexRs, idexRt, idexDestReg  out  REG_ADDR_WIDTH  register indices for forwarding and write-back
- idexRegWrite, idexMemRead  out  1  gated control signals
- idexOpcode, idexFunct  out  6  decoded instruction fields
- idexShamt  out  5  decoded shift amount

## Operation
- Field split: opcode[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6], funct[5:0], imm[15:0].
- Register file:
  - Register 0 reads 0 and ignores writes.
  - A write occurs on the rising edge when wbRegWrite=1 and wbWriteReg≠0.
  - resetN low clears every register to 0 asynchronously.
- Write-through bypass: if wbRegWrite=1, wbWriteReg≠0 and wbWriteReg equals rs (or rt), that read port returns wbWriteData in the same cycle.
- Immediate extension:
  - Opcodes 0x0C, 0x0D, 0x0E (andi/ori/xori): zero-extend.
  - Opcode 0x0F (lui): {imm, 16'b0}, zero-extended to DATA_WIDTH.
  - All other opcodes: sign-extend.
- destReg = regDst ? rd : rt. Effective regWrite = regWrite & ifValid & (destReg≠0).
- stallOut = ifValid & exMemRead & (exRt≠0) & (exRt==rs | exRt==rt).
- ID/EX update each rising edge, in priority order:
  - resetN low: every idex output is 0 (asynchronous).
  - flush=1: bubble. idexValid, idexRegWrite, idexMemRead = 0; all data and index fields = 0.
  - stallOut=1: same bubble as flush. The held instruction re-decodes next cycle.
  - Otherwise: load all fields. idexValid = ifValid; control outputs use the gated values; data fields load even when ifValid=0.
- Flush and stall in the same cycle: a single bubble; flush wins and stallOut still reflects its equation.
- Reset release mid-stream: the first edge after resetN rises loads normally.

## Timing
- Decode-to-ID/EX latency: 1 cycle. Values sampled at edge N appear on idex outputs after edge N.
- stallOut is combinational from instruction32, ifValid, exMemRead and exRt; there is no registered path.
- A write-back at edge N is visible through the bypass during cycle N and stored in the file from edge N on.
- Simultaneous write-back to rs and a load-use match: the stall still asserts (the bypass does not cancel it).
- The register file has no read latency. The only state is the file plus the ID/EX register.

## Test plan
- Reset: hold resetN=0 with arbitrary inputs, then release with no write-back → every idex output and stallOut are 0; reading reg 5 returns 0.
- Write then read: wbRegWrite=1, wbWriteReg=8, wbWriteData=0xDEADBEEF, with instruction32=0x01095020 (add $10,$8,$9), regDst=1, regWrite=1 in the same cycle → after the edge idexReadData1=0xDEADBEEF (bypass), idexDestReg=10, idexRegWrite=1. Write to reg 0 → a later read of reg 0 returns 0.
- Immediate modes:
  - 0x3508FFFF (ori) → idexExtImm=0x0000FFFF.
  - 0x2108FFFF (addi) → 0xFFFFFFFF.
  - 0x3C081234 (lui) → 0x12340000.
  - Repeat with DATA_WIDTH=64 to check sign fill.
- Load-use: exMemRead=1, exRt=8, instruction reads rs=8 → stallOut=1 and the next idex contents are a bubble (idexValid=0, idexRegWrite=0); with exRt=0 → no stall.
- Flush priority: flush=1 together with a stall condition and a valid add → a single bubble, with all idex fields 0.
- Zero destination: add with rd=0, regDst=1, regWrite=1 → idexRegWrite=0, idexValid=1.
